// File: rtl/top_datapath_pkg.sv
// Shared definitions for the mixing datapath: field widths, field positions
// inside the 117-bit result word, the packed result type, and the helper
// that computes the per-cycle signature input.
package top_datapath_pkg;

    localparam int SUM_W  = 22;
    localparam int PROD_W = 26;
    localparam int ACC_W  = 32;
    localparam int ROT_W  = 21;
    localparam int SIG_W  = 16;

    localparam int SUM_LSB  = 95;
    localparam int PROD_LSB = 69;
    localparam int ACC_LSB  = 37;
    localparam int ROT_LSB  = 16;
    localparam int SIG_LSB  = 0;

    localparam int Y_W = SUM_W + PROD_W + ACC_W + ROT_W + SIG_W;

    // Field order matches the bit layout of y, MSB first.
    typedef struct packed {
        logic [SUM_W-1:0]  sum;
        logic [PROD_W-1:0] prod;
        logic [ACC_W-1:0]  acc;
        logic [ROT_W-1:0]  rot;
        logic [SIG_W-1:0]  sig;
    } result_t;

    // Value XORed into the rotated signature each cycle. The 8-bit operand
    // is duplicated to cover all 16 signature bits.
    function automatic logic [SIG_W-1:0] sig_fold(
        input logic [15:0] a,
        input logic [7:0]  b,
        input logic [15:0] c,
        input logic [15:0] d
    );
        return a ^ d ^ c ^ {b, b};
    endfunction

endpackage

// File: rtl/top_datapath_rotl21.sv
// Combinational 21-bit left rotator.
// Ports:
//   din  [20:0]  word to rotate
//   amt  [3:0]   rotate-left amount, 0..15
//   dout [20:0]  rotated word
module rotl21
    import top_datapath_pkg::*;
(
    input  logic [ROT_W-1:0] din,
    input  logic [3:0]       amt,
    output logic [ROT_W-1:0] dout
);

    logic [2*ROT_W-1:0] dbl;

    // Shifting the doubled word left leaves the rotated pattern in the
    // upper half; bits shifted out of the lower copy supply the wrap.
    always_comb begin
        dbl  = {din, din} << amt;
        dout = dbl[2*ROT_W-1:ROT_W];
    end

endmodule

// File: rtl/top_datapath.sv
// Registered mixing datapath. Every clock it combines four input words into
// one 117-bit result: signed sum, unsigned product, running accumulator,
// rotation and rolling XOR signature. All fields are registered, one cycle
// of latency, and y is driven only from flops.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset, clears every field
//   wire0 [20:0] signed operand A
//   wire1 [7:0]  unsigned operand / rotate amount (low nibble)
//   wire2 [17:0] unsigned operand B
//   wire3 [20:0] signed operand C
//   y     [116:0] {sum, prod, acc, rot, sig}
module top_datapath
    import top_datapath_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [20:0]      wire0,
    input  logic [7:0]       wire1,
    input  logic [17:0]      wire2,
    input  logic [20:0]      wire3,
    output logic [Y_W-1:0]   y
);

    result_t          r_q;
    logic [ROT_W-1:0] rot_w;
    logic [SIG_W-1:0] fold_w;

    rotl21 u_rotl21 (
        .din  (wire3),
        .amt  (wire1[3:0]),
        .dout (rot_w)
    );

    assign fold_w = sig_fold(wire0[15:0], wire1, wire2[15:0], wire3[15:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q.sum  <= {wire0[20], wire0} + {wire3[20], wire3};
            r_q.prod <= {8'b0, wire2} * {18'b0, wire1};
            // Accumulator wraps modulo 2^32 by design.
            r_q.acc  <= r_q.acc + {{11{wire0[20]}}, wire0};
            r_q.rot  <= rot_w;
            r_q.sig  <= {r_q.sig[SIG_W-2:0], r_q.sig[SIG_W-1]} ^ fold_w;
        end
    end

    assign y[SUM_LSB  +: SUM_W]  = r_q.sum;
    assign y[PROD_LSB +: PROD_W] = r_q.prod;
    assign y[ACC_LSB  +: ACC_W]  = r_q.acc;
    assign y[ROT_LSB  +: ROT_W]  = r_q.rot;
    assign y[SIG_LSB  +: SIG_W]  = r_q.sig;

endmodule

// File: tb/tb_top_datapath.sv
// Self-checking bench for top_datapath: directed cases plus randomized
// vectors compared against an arithmetic reference model.
module tb_top_datapath;

    logic         clk;
    logic         rst;
    logic [20:0]  wire0;
    logic [7:0]   wire1;
    logic [17:0]  wire2;
    logic [20:0]  wire3;
    logic [116:0] y;

    int n_vec;
    int n_err;

    // reference model state
    logic [31:0]  m_acc;
    logic [15:0]  m_sig;
    logic [116:0] m_y;

    top_datapath dut (
        .clk   (clk),
        .rst   (rst),
        .wire0 (wire0),
        .wire1 (wire1),
        .wire2 (wire2),
        .wire3 (wire3),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [116:0] got, input logic [116:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one vector, clock it, advance the model and compare all of y.
    task automatic apply(input logic r, input logic [20:0] a, input logic [7:0] b,
                         input logic [17:0] c, input logic [20:0] d);
        int          s;
        longint      p;
        int          k;
        longint      rl;
        logic [15:0] fold;
        rst = r; wire0 = a; wire1 = b; wire2 = c; wire3 = d;
        @(posedge clk);
        if (r) begin
            m_acc = '0;
            m_sig = '0;
            m_y   = '0;
        end else begin
            s     = int'($signed(a)) + int'($signed(d));
            p     = longint'(c) * longint'(b);
            m_acc = m_acc + 32'($signed(a));
            k     = int'(b) % 16;
            rl    = ((longint'(d) << k) | (longint'(d) >> (21 - k))) & 64'h1FFFFF;
            fold  = a[15:0] ^ b * 16'h0101 ^ c[15:0] ^ d[15:0];
            m_sig = 16'((m_sig << 1) | (m_sig >> 15)) ^ fold;
            m_y   = {22'(s), 26'(p), m_acc, 21'(rl), m_sig};
        end
        #1 chk("y", y, m_y);
    endtask

    task automatic apply_rand(input logic r);
        apply(r, 21'($urandom), 8'($urandom), 18'($urandom), 21'($urandom));
    endtask

    initial begin
        logic [20:0] a;
        n_vec = 0; n_err = 0;
        m_acc = '0; m_sig = '0; m_y = '0;
        rst = 1'b1; wire0 = '0; wire1 = '0; wire2 = '0; wire3 = '0;

        // reset with random inputs, then release with zero inputs
        apply_rand(1'b1);
        apply_rand(1'b1);
        chk("rst_y", y, 117'h0);
        apply(1'b0, 21'h0, 8'h0, 18'h0, 21'h0);
        chk("rst_release_y", y, 117'h0);

        // sum / accumulator with -1 operands
        apply(1'b1, 21'h0, 8'h0, 18'h0, 21'h0);
        apply(1'b0, 21'h1FFFFF, 8'h0, 18'h0, 21'h1FFFFF);
        chk("sum_neg", y[116:95], 22'h3FFFFE);
        chk("acc_e1", y[68:37], 32'hFFFFFFFF);
        apply(1'b0, 21'h1FFFFF, 8'h0, 18'h0, 21'h1FFFFF);
        chk("acc_e2", y[68:37], 32'hFFFFFFFE);

        // product extremes
        apply(1'b0, 21'h0, 8'hFF, 18'h3FFFF, 21'h0);
        chk("prod_max", y[94:69], 26'h3FBFF01);
        apply(1'b0, 21'h0, 8'h00, 18'h3FFFF, 21'h0);
        chk("prod_zero", y[94:69], 26'h0);

        // rotation
        apply(1'b0, 21'h0, 8'h05, 18'h0, 21'h000001);
        chk("rot_5", y[36:16], 21'h000020);
        apply(1'b0, 21'h0, 8'h14, 18'h0, 21'h000001);
        chk("rot_hi_nib", y[36:16], 21'h000010);
        apply(1'b0, 21'h0, 8'h01, 18'h0, 21'h100000);
        chk("rot_wrap", y[36:16], 21'h000001);

        // signature
        apply(1'b1, 21'h0, 8'h0, 18'h0, 21'h0);
        apply(1'b0, 21'h001234, 8'h0, 18'h0, 21'h0);
        chk("sig_e1", y[15:0], 16'h1234);
        apply(1'b0, 21'h001234, 8'h0, 18'h0, 21'h0);
        chk("sig_e2", y[15:0], 16'h365C);

        // reset mid-run
        for (int i = 0; i < 50 && m_acc == 32'h0; i++) apply_rand(1'b0);
        chk("acc_nonzero", 117'(y[68:37] != 32'h0), 117'h1);
        apply_rand(1'b1);
        chk("midrun_rst_y", y, 117'h0);
        a = 21'($urandom);
        apply(1'b0, a, 8'($urandom), 18'($urandom), 21'($urandom));
        chk("acc_restart", y[68:37], 32'($signed(a)));

        // random soak with occasional reset
        for (int i = 0; i < 400; i++) apply_rand(($urandom % 25) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
